// File: rtl/tag_release_queue_pkg.sv
// Shared types and sizing for the in-order tag release queue.
// Tag encoding, queue index/pointer types and the per-entry record live here.
package tag_release_queue_pkg;

  typedef enum logic {
    ENC_BINARY = 1'b0,
    ENC_ONEHOT = 1'b1
  } tag_enc_e;

  localparam bit       BIT_VEC = 1'b1;
  localparam tag_enc_e TAG_ENC = BIT_VEC ? ENC_ONEHOT : ENC_BINARY;

  localparam int DEPTH   = 16;
  localparam int TAGS    = 16;
  localparam int ALLOC   = 4;
  localparam int RELEASE = 4;
  localparam int CMPL    = 4;

  localparam int DATA = (TAG_ENC == ENC_ONEHOT) ? TAGS : $clog2(TAGS);
  localparam int IDX  = $clog2(DEPTH);
  localparam int NREL = $clog2(RELEASE + 1);
  localparam int NALC = $clog2(ALLOC + 1);

  typedef logic [DATA-1:0] tag_t;
  typedef logic [IDX-1:0]  idx_t;
  typedef logic [IDX:0]    ptr_t;   // index plus wrap bit
  typedef logic [IDX:0]    cnt_t;
  typedef logic [NREL-1:0] rel_cnt_t;
  typedef logic [NALC-1:0] alloc_cnt_t;

  typedef struct packed {
    logic valid;
    logic done;
    tag_t tag;
  } entry_t;

endpackage

// File: rtl/tag_release_queue_if.sv
// Allocation, completion and release signals between the queue and its
// freelist/completion neighbours.
interface tag_release_queue_if;
  import tag_release_queue_pkg::*;

  logic               flush_;
  logic [ALLOC-1:0]   alloc_;
  tag_t [ALLOC-1:0]   alloc_tag;
  idx_t [ALLOC-1:0]   alloc_idx;
  logic [CMPL-1:0]    done_;
  idx_t [CMPL-1:0]    done_idx;
  logic [RELEASE-1:0] rel_;
  tag_t [RELEASE-1:0] rel_tag;
  logic               full;
  cnt_t               count;

  modport master (
    output flush_, alloc_, alloc_tag, done_, done_idx,
    input  alloc_idx, rel_, rel_tag, full, count
  );

  modport slave (
    input  flush_, alloc_, alloc_tag, done_, done_idx,
    output alloc_idx, rel_, rel_tag, full, count
  );

endinterface

// File: rtl/tag_rel_scan.sv
// Leading-ones counter over the head window: how many entries from the head
// are both valid and done, and the matching per-lane release mask.
module tag_rel_scan
  import tag_release_queue_pkg::*;
(
  input  logic [RELEASE-1:0] ready,
  output rel_cnt_t           n,
  output logic [RELEASE-1:0] mask
);

  always_comb begin
    logic run;
    // NOTE: every output of a combinational block gets a default first so no
    // path through the loop can leave it unassigned and infer a latch.
    run  = 1'b1;
    n    = '0;
    mask = '0;
    for (int i = 0; i < RELEASE; i++) begin
      run     = run & ready[i];
      mask[i] = run;
      n       = n + rel_cnt_t'(run);
    end
  end

endmodule

// File: rtl/tag_release_queue.sv
// In-order tag return path: records tags as the freelist serves them, marks
// completions per entry and hands tags back oldest-first.
module tag_release_queue
  import tag_release_queue_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  tag_release_queue_if.slave  bus
);

  entry_t             q [DEPTH];
  ptr_t               head;
  ptr_t               tail;
  cnt_t               count_q;

  logic [RELEASE-1:0] ready;
  logic [RELEASE-1:0] rel_mask;
  rel_cnt_t           n_rel;
  idx_t [RELEASE-1:0] rel_idx;

  alloc_cnt_t         n_alloc;
  idx_t [ALLOC-1:0]   wr_idx;
  logic               full_w;
  logic               alloc_ok;

  always_comb begin
    for (int i = 0; i < RELEASE; i++) begin
      rel_idx[i] = head[IDX-1:0] + idx_t'(i);
      ready[i]   = q[rel_idx[i]].valid & q[rel_idx[i]].done;
    end
  end

  tag_rel_scan u_scan (
    .ready (ready),
    .n     (n_rel),
    .mask  (rel_mask)
  );

  // Release outputs depend only on registered state, except that a flush
  // suppresses them in the same cycle the freelist is being flushed.
  always_comb begin
    bus.rel_    = '1;
    bus.rel_tag = '0;
    for (int i = 0; i < RELEASE; i++) begin
      if (rel_mask[i] && bus.flush_) begin
        bus.rel_[i]    = 1'b0;
        bus.rel_tag[i] = q[rel_idx[i]].tag;
      end
    end
  end

  // Active lanes are packed in lane order starting at the tail.
  always_comb begin
    alloc_cnt_t k;
    k = '0;
    for (int l = 0; l < ALLOC; l++) begin
      wr_idx[l] = tail[IDX-1:0] + idx_t'(k);
      if (!bus.alloc_[l]) k = k + alloc_cnt_t'(1);
    end
    n_alloc = k;
  end

  assign full_w        = count_q > cnt_t'(DEPTH - ALLOC);
  assign alloc_ok      = !full_w;
  assign bus.alloc_idx = wr_idx;
  assign bus.full      = full_w;
  assign bus.count     = count_q;

  always_ff @(posedge clk) begin
    if (reset || !bus.flush_) begin
      // NOTE: only the valid/done control bits are reset; a tag payload is
      // never read before its valid bit is set, so the tag storage needs no reset.
      for (int i = 0; i < DEPTH; i++) begin
        q[i].valid <= 1'b0;
        q[i].done  <= 1'b0;
      end
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      for (int c = 0; c < CMPL; c++) begin
        if (!bus.done_[c] && q[bus.done_idx[c]].valid)
          q[bus.done_idx[c]].done <= 1'b1;
      end
      // Release clears come after completions so a late completion of a
      // retiring entry cannot resurrect it.
      for (int i = 0; i < RELEASE; i++) begin
        if (rel_mask[i]) begin
          q[rel_idx[i]].valid <= 1'b0;
          q[rel_idx[i]].done  <= 1'b0;
        end
      end
      if (alloc_ok) begin
        for (int l = 0; l < ALLOC; l++) begin
          if (!bus.alloc_[l])
            q[wr_idx[l]] <= '{valid: 1'b1, done: 1'b0, tag: bus.alloc_tag[l]};
        end
        tail <= tail + ptr_t'(n_alloc);
      end
      head    <= head + ptr_t'(n_rel);
      count_q <= count_q + (alloc_ok ? cnt_t'(n_alloc) : cnt_t'(0)) - cnt_t'(n_rel);
    end
  end

endmodule

// File: tb/tb_tag_release_queue.sv
// Directed bench for tag_release_queue: in-order release, packing, full drop,
// wrap-around, release capping, flush and reset priority.
module tb_tag_release_queue;
  import tag_release_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tag_release_queue_if bus ();

  tag_release_queue dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tag driven for queue entry e: a fixed permutation so slot mix-ups show.
  function automatic tag_t exp_tag(input int e);
    int id;
    id = ((e % DEPTH) * 5 + 3) % TAGS;
    return (TAG_ENC == ENC_ONEHOT) ? (tag_t'(1) << id) : tag_t'(id);
  endfunction

  task automatic idle();
    bus.flush_    = 1'b1;
    bus.alloc_    = '1;
    bus.alloc_tag = '0;
    bus.done_     = '1;
    bus.done_idx  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_alloc(input logic [ALLOC-1:0] mask, input int base);
    int k;
    k = 0;
    bus.alloc_ = mask;
    for (int l = 0; l < ALLOC; l++) begin
      bus.alloc_tag[l] = '0;
      if (!mask[l]) begin
        bus.alloc_tag[l] = exp_tag(base + k);
        k++;
      end
    end
  endtask

  task automatic drive_done(input logic [CMPL-1:0] mask, input int i0, input int i1,
                            input int i2, input int i3);
    bus.done_       = mask;
    bus.done_idx[0] = idx_t'(i0);
    bus.done_idx[1] = idx_t'(i1);
    bus.done_idx[2] = idx_t'(i2);
    bus.done_idx[3] = idx_t'(i3);
  endtask

  task automatic check_rel(input string nm, input logic [RELEASE-1:0] exp_rel, input int first);
    check({nm, "_rel"}, 32'(bus.rel_), 32'(exp_rel));
    for (int i = 0; i < RELEASE; i++)
      check($sformatf("%s_tag%0d", nm, i), 32'(bus.rel_tag[i]),
            exp_rel[i] ? 32'd0 : 32'(exp_tag(first + i)));
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_rel", 32'(bus.rel_), 32'hF);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);

    // Four-lane enqueue into an empty queue.
    drive_alloc(4'b0000, 0);
    settle();
    check("a4_idx0", 32'(bus.alloc_idx[0]), 32'd0);
    check("a4_idx1", 32'(bus.alloc_idx[1]), 32'd1);
    check("a4_idx2", 32'(bus.alloc_idx[2]), 32'd2);
    check("a4_idx3", 32'(bus.alloc_idx[3]), 32'd3);
    tick(); idle(); settle();
    check("a4_count", 32'(bus.count), 32'd4);
    check("a4_norel", 32'(bus.rel_), 32'hF);

    // Younger entries complete first: nothing may leave.
    drive_done(4'b1000, 1, 2, 3, 0);
    tick(); idle(); settle();
    check("young_done_rel", 32'(bus.rel_), 32'hF);

    // Head completes: all four go next cycle, in order.
    drive_done(4'b1110, 0, 0, 0, 0);
    tick(); idle(); settle();
    check_rel("rel4", 4'b0000, 0);
    tick(); settle();
    check("rel4_count", 32'(bus.count), 32'd0);
    check("rel4_after", 32'(bus.rel_), 32'hF);

    // Sparse lane packing.
    drive_alloc(4'b1110, 4);
    settle();
    check("a1_idx0", 32'(bus.alloc_idx[0]), 32'd4);
    tick();
    drive_alloc(4'b1010, 5);
    settle();
    check("pack_idx0", 32'(bus.alloc_idx[0]), 32'd5);
    check("pack_idx2", 32'(bus.alloc_idx[2]), 32'd6);
    tick(); idle(); settle();
    check("pack_count", 32'(bus.count), 32'd3);

    // Fill to 13 (enqueue wraps 15 -> 0).
    drive_alloc(4'b0000, 7);  tick();
    drive_alloc(4'b0000, 11); tick();
    drive_alloc(4'b1100, 15);
    settle();
    check("fill_idx1_wrap", 32'(bus.alloc_idx[1]), 32'd0);
    tick(); idle(); settle();
    check("fill_count", 32'(bus.count), 32'd13);
    check("fill_full", 32'(bus.full), 32'd1);

    // Allocation while full is dropped whole.
    drive_alloc(4'b0000, 1);
    tick(); idle(); settle();
    check("drop_count", 32'(bus.count), 32'd13);

    // Release two; full clears the cycle after the release.
    drive_done(4'b1100, 4, 5, 0, 0);
    tick(); idle(); settle();
    check_rel("rel2", 4'b1100, 4);
    check("rel2_full_same", 32'(bus.full), 32'd1);
    tick(); settle();
    check("rel2_count", 32'(bus.count), 32'd11);
    check("rel2_full_next", 32'(bus.full), 32'd0);

    // Six contiguous done entries: 4 then 2.
    drive_done(4'b0000, 6, 7, 8, 9);
    tick();
    drive_done(4'b1100, 10, 11, 0, 0);
    settle();
    check_rel("run4", 4'b0000, 6);
    tick(); idle(); settle();
    check_rel("run2", 4'b1100, 10);
    tick(); settle();
    check("run_count", 32'(bus.count), 32'd5);

    // Release 12,13 while enqueueing one entry at index 1 (tail untouched by the drop).
    drive_done(4'b1100, 12, 13, 0, 0);
    tick(); idle();
    drive_alloc(4'b1110, 1);
    settle();
    check_rel("rel1213", 4'b1100, 12);
    check("mix_idx0", 32'(bus.alloc_idx[0]), 32'd1);
    tick(); idle(); settle();
    check("mix_count", 32'(bus.count), 32'd4);

    // Release run straddling 15 -> 0.
    drive_done(4'b0000, 14, 15, 0, 1);
    tick(); idle(); settle();
    check_rel("wrap", 4'b0000, 14);
    tick(); settle();
    check("wrap_count", 32'(bus.count), 32'd0);
    drive_alloc(4'b1110, 2);
    settle();
    check("wrap_tail_idx", 32'(bus.alloc_idx[0]), 32'd2);
    tick();
    drive_alloc(4'b1100, 3);
    tick(); idle(); settle();
    check("pre_flush_count", 32'(bus.count), 32'd3);

    // Flush while three entries are done at the head.
    drive_done(4'b1000, 2, 3, 4, 0);
    tick(); idle();
    bus.flush_ = 1'b0;
    drive_alloc(4'b0000, 5);
    drive_done(4'b0000, 2, 3, 4, 5);
    settle();
    check("flush_rel", 32'(bus.rel_), 32'hF);
    tick(); idle(); settle();
    check("flush_count", 32'(bus.count), 32'd0);
    check("flush_after_rel", 32'(bus.rel_), 32'hF);
    drive_alloc(4'b1110, 0);
    settle();
    check("flush_tail_idx", 32'(bus.alloc_idx[0]), 32'd0);

    // Reset dominates flush_ and allocation strobes.
    reset      = 1'b1;
    bus.flush_ = 1'b0;
    drive_alloc(4'b0000, 0);
    tick();
    reset = 1'b0;
    idle();
    settle();
    check("rst2_count", 32'(bus.count), 32'd0);
    check("rst2_rel", 32'(bus.rel_), 32'hF);
    check("rst2_full", 32'(bus.full), 32'd0);
    drive_alloc(4'b1110, 0);
    settle();
    check("rst2_tail_idx", 32'(bus.alloc_idx[0]), 32'd0);
    tick(); idle(); settle();
    check("rst2_count1", 32'(bus.count), 32'd1);

    // Completion aimed at a non-valid index is ignored.
    drive_done(4'b1110, 5, 0, 0, 0);
    tick(); idle(); settle();
    check("bogus_done_rel", 32'(bus.rel_), 32'hF);
    check("bogus_done_count", 32'(bus.count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
